address_request_arbiter: RTL and testbench
==========================================

// Module: address_request_arbiter
// PURPOSE
//  Shares the single memory-storage address port between NREQ address generators (counters, pattern sources).
//  Each requester gets a one-entry holding slot; a round-robin scheduler issues one held address per cycle
//  to storage while storage_ready is high, with the existing address + one-cycle new-address strobe convention.
//  Sits between the address generators and the memory storage block.
// PARAMETERS
//  NREQ      4                               number of requesters (2..8)
//  ADDRBITS  LETTERINDEXBITS+WORDINDEXBITS   address width ({x,y} packed), from MyParameters.vh
//  IDBITS    3                               width of grant_id; must satisfy 2**IDBITS >= NREQ
// PORTS
//  clock            in   1              single clock; all logic on posedge clock
//  reset            in   1              synchronous, active-high
//  req_address      in   NREQ*ADDRBITS  requester i address at [i*ADDRBITS +: ADDRBITS]
//  req_valid        in   NREQ           one-cycle request strobe per requester
//  req_accept       out  NREQ           1 = requester i slot empty; a strobe this cycle is captured
//  storage_ready    in   1              storage can take an address this cycle
//  mem_address      out  ADDRBITS       issued address (registered)
//  mem_new_address  out  1              one-cycle strobe: mem_address is new
//  grant_id         out  IDBITS         requester index of the current mem_address
//  drop_count       out  8              saturating count of discarded requests
// BEHAVIOUR
//  Reset: all slots empty; mem_address=0, mem_new_address=0, grant_id=0, drop_count=0;
//   round-robin pointer=NREQ-1, so requester 0 has first priority. Reset mid-operation discards held slots.
//  req_accept[i] = ~slot_full[i] (combinational from state only, no path from req_valid).
//  Capture: req_valid[i] & req_accept[i] at edge E -> slot i full with that address after E.
//  Drop: req_valid[i] & ~req_accept[i] -> request discarded, drop_count+1 (saturates at 255).
//  Issue: at edge E+1, if storage_ready & any slot full: winner = first full slot after pointer
//   (wrap NREQ-1 -> 0). Register mem_address=slot addr, grant_id=winner, mem_new_address=1;
//   clear winner slot; pointer=winner. Minimum latency: strobe at E -> mem_new_address high
//   the cycle after E+1 (2 cycles).
//  mem_new_address is high for exactly one cycle per issue; back-to-back issues give consecutive strobes.
//  storage_ready low or no full slot: mem_new_address=0; mem_address and grant_id hold.
//  A slot cleared at edge E accepts again from the cycle after E; no same-edge refill.
//  Multiple simultaneous req_valid to distinct empty slots: all captured.
//  Only the winner's slot is cleared; losers keep their addresses unchanged.
//  Address values are opaque; no range check, no arithmetic on them.
// CONFIGURATION
//  ARB_DUP_FILTER_EN defined: winner whose address equals the last issued mem_address
//   (only after at least one issue since reset) is cleared, pointer advances,
//   mem_new_address stays 0, mem_address/grant_id hold, drop_count+1.
//   Both a drop and a duplicate in the same cycle -> drop_count+2, saturating at 255.
//  Not defined: every winner is issued, duplicates included.
// STRUCTURE
//  Package arb_pkg.vh: NREQ default, ADDRBITS derivation, IDBITS, DROPCNT_W=8.
//  Sub-module address_request_slot: one-entry holding register.
//   Ports: clock, reset, load, clear, d, q, full.
//   Instantiated NREQ times via generate.
//  Top level holds the round-robin picker, output registers and drop counter.
// TESTING
//  1 Reset, then req_valid[2] with addr 0x84 and storage_ready=1 -> mem_address=0x84, grant_id=2,
//    mem_new_address high exactly 2 cycles after the strobe, then low.
//  2 All 4 requesters strobe in the same cycle (0x10, 0x20, 0x30, 0x40), storage_ready=1
//    -> issue order 0,1,2,3 on 4 consecutive cycles; then req 3 and req 0 strobe -> 0 issued before 3.
//  3 storage_ready=0 while req 1 holds 0x55; strobe req 1 again -> req_accept[1]=0, drop_count=1;
//    storage_ready=1 -> 0x55 issued once.
//  4 Reset asserted while 3 slots are full -> all req_accept=1 and no mem_new_address after
//    reset deasserts; drop_count=0.
//  5 Hold 300 drops with storage_ready=0 -> drop_count saturates at 255.
//  6 ARB_DUP_FILTER_EN: issue 0x84, then req 1 sends 0x84 -> no strobe, drop_count+1.
//    Without the macro -> second strobe with 0x84.

Source files
------------

// File: rtl/address_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : address_request_arbiter_pkg
// Description : Shared constants and helpers for the address request arbiter.
//               Address width is built from the letter/word index widths
//               ({x,y} packed), as used by the memory storage block.
// Revision    : 1.0 - initial release
// ============================================================================
package address_request_arbiter_pkg;

    localparam int c_LETTERINDEXBITS = 4;
    localparam int c_WORDINDEXBITS   = 4;

    localparam int c_NREQ      = 4;
    localparam int c_ADDRBITS  = c_LETTERINDEXBITS + c_WORDINDEXBITS;
    localparam int c_IDBITS    = 3;
    localparam int c_DROPCNT_W = 8;

    localparam int c_DROPCNT_MAX = (1 << c_DROPCNT_W) - 1;

    // Saturating add for the drop counter. The increment can exceed one when
    // several requesters are refused in the same cycle (plus a filtered
    // duplicate), so the clamp is done on the full sum.
    function automatic logic [c_DROPCNT_W-1:0] drop_sat_add(
        input logic [c_DROPCNT_W-1:0] count,
        input logic [3:0]             inc
    );
        int sum;
        sum = int'(count) + int'(inc);
        if (sum > c_DROPCNT_MAX) begin
            sum = c_DROPCNT_MAX;
        end
        return c_DROPCNT_W'(sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : address_request_arbiter_if
// Description : Requester and storage-side signals of the address request
//               arbiter.
//   req_address     NREQ*ADDRBITS  requester i address at [i*ADDRBITS +: ADDRBITS]
//   req_valid       NREQ           one-cycle request strobe per requester
//   req_accept      NREQ           1 = slot i empty, a strobe is captured
//   storage_ready   1              storage can take an address this cycle
//   mem_address     ADDRBITS       issued address (registered)
//   mem_new_address 1              one-cycle strobe: mem_address is new
//   grant_id        IDBITS         requester index of current mem_address
//   drop_count      8              saturating count of discarded requests
//   modport slave  : the arbiter
//   modport master : requesters + storage (e.g. a testbench)
// Revision    : 1.0 - initial release
// ============================================================================
interface address_request_arbiter_if
    import address_request_arbiter_pkg::*;
#(
    parameter int NREQ     = c_NREQ,
    parameter int ADDRBITS = c_ADDRBITS,
    parameter int IDBITS   = c_IDBITS
) ();

    logic [NREQ*ADDRBITS-1:0] req_address;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_accept;
    logic                     storage_ready;
    logic [ADDRBITS-1:0]      mem_address;
    logic                     mem_new_address;
    logic [IDBITS-1:0]        grant_id;
    logic [c_DROPCNT_W-1:0]   drop_count;

    modport slave (
        input  req_address,
        input  req_valid,
        input  storage_ready,
        output req_accept,
        output mem_address,
        output mem_new_address,
        output grant_id,
        output drop_count
    );

    modport master (
        output req_address,
        output req_valid,
        output storage_ready,
        input  req_accept,
        input  mem_address,
        input  mem_new_address,
        input  grant_id,
        input  drop_count
    );

endinterface
`default_nettype wire

// File: rtl/address_request_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module      : address_request_slot
// Description : One-entry holding register for a single requester.
//   clock  in   clock
//   reset  in   synchronous, active-high; empties the slot
//   load   in   capture d and mark full (only issued while empty)
//   clear  in   mark empty (only issued while full); wins over load
//   d      in   WIDTH  address to capture
//   q      out  WIDTH  held address
//   full   out  slot holds an address
// Revision    : 1.0 - initial release
// ============================================================================
module address_request_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    logic [WIDTH-1:0] r_q;
    logic             r_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= '0;
            r_full <= 1'b0;
        end else if (clear) begin
            r_full <= 1'b0;
        end else if (load) begin
            r_q    <= d;
            r_full <= 1'b1;
        end
    end

    assign q    = r_q;
    assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/address_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : address_request_arbiter
// Description : Shares the memory-storage address port between NREQ address
//               generators. Each requester owns a one-entry slot; a
//               round-robin picker issues one held address per cycle while
//               storage_ready is high, as registered address plus a
//               one-cycle mem_new_address strobe.
//   clock  in   single clock, posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of address_request_arbiter_if (requester inputs,
//          storage_ready, mem_address/mem_new_address/grant_id/drop_count)
// Config      : ARB_DUP_FILTER_EN - suppress a winner whose address equals
//               the last issued address (counted as a drop).
// Revision    : 1.0 - initial release
// ============================================================================
module address_request_arbiter
    import address_request_arbiter_pkg::*;
#(
    parameter int NREQ     = c_NREQ,
    parameter int ADDRBITS = c_ADDRBITS,
    parameter int IDBITS   = c_IDBITS
) (
    input  logic                     clock,
    input  logic                     reset,
    address_request_arbiter_if.slave bus
);

    logic [NREQ-1:0]                w_slot_full;
    logic [NREQ-1:0]                w_load;
    logic [NREQ-1:0]                w_clear;
    logic [NREQ-1:0][ADDRBITS-1:0]  w_slot_addr;

    logic                           w_any_full;
    logic [IDBITS-1:0]              w_winner;
    logic [ADDRBITS-1:0]            w_winner_addr;
    logic                           w_take;
    logic                           w_issue;
    logic [3:0]                     w_drop_inc;

    logic [IDBITS-1:0]              r_ptr;
    logic [ADDRBITS-1:0]            r_mem_address;
    logic                           r_mem_new_address;
    logic [IDBITS-1:0]              r_grant_id;
    logic [c_DROPCNT_W-1:0]         r_drop_count;

    // ------------------------------------------------------------------
    // Holding slots. Load only into an empty slot and clear only the
    // winner, which is always full, so the two never collide; a slot
    // cleared at an edge therefore refills no earlier than the next one.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign w_load[gi]  = bus.req_valid[gi] & ~w_slot_full[gi];
            assign w_clear[gi] = w_take & (w_winner == IDBITS'(gi));

            address_request_slot #(
                .WIDTH (ADDRBITS)
            ) u_slot (
                .clock (clock),
                .reset (reset),
                .load  (w_load[gi]),
                .clear (w_clear[gi]),
                .d     (bus.req_address[gi*ADDRBITS +: ADDRBITS]),
                .q     (w_slot_addr[gi]),
                .full  (w_slot_full[gi])
            );
        end
    endgenerate

    // Acceptance depends on slot state only, never on req_valid.
    assign bus.req_accept = ~w_slot_full;

    // ------------------------------------------------------------------
    // Round-robin picker: scan slots starting just after the last winner.
    // ------------------------------------------------------------------
    always_comb begin
        w_any_full    = 1'b0;
        w_winner      = '0;
        w_winner_addr = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_any_full && w_slot_full[i] &&
                    (i == (int'(r_ptr) + k) % NREQ)) begin
                    w_any_full    = 1'b1;
                    w_winner      = IDBITS'(i);
                    w_winner_addr = w_slot_addr[i];
                end
            end
        end
    end

    // w_take frees the winner's slot and moves the pointer; w_issue is the
    // subset that actually reaches storage.
    assign w_take = bus.storage_ready & w_any_full;

`ifdef ARB_DUP_FILTER_EN
    logic r_issued_once;
    logic w_dup;

    // Comparison against mem_address is only meaningful once something
    // has been issued; the reset value 0 is not a real prior address.
    assign w_dup   = w_take & r_issued_once & (w_winner_addr == r_mem_address);
    assign w_issue = w_take & ~w_dup;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issued_once <= 1'b0;
        end else if (w_issue) begin
            r_issued_once <= 1'b1;
        end
    end
`else
    assign w_issue = w_take;
`endif

    // Every refused strobe counts, so several can land in one cycle.
    always_comb begin
        w_drop_inc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] & w_slot_full[i]) begin
                w_drop_inc = w_drop_inc + 4'd1;
            end
        end
`ifdef ARB_DUP_FILTER_EN
        if (w_dup) begin
            w_drop_inc = w_drop_inc + 4'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output registers, pointer and drop counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr             <= IDBITS'(NREQ - 1);
            r_mem_address     <= '0;
            r_mem_new_address <= 1'b0;
            r_grant_id        <= '0;
            r_drop_count      <= '0;
        end else begin
            r_mem_new_address <= w_issue;
            if (w_issue) begin
                r_mem_address <= w_winner_addr;
                r_grant_id    <= w_winner;
            end
            if (w_take) begin
                r_ptr <= w_winner;
            end
            r_drop_count <= drop_sat_add(r_drop_count, w_drop_inc);
        end
    end

    assign bus.mem_address     = r_mem_address;
    assign bus.mem_new_address = r_mem_new_address;
    assign bus.grant_id        = r_grant_id;
    assign bus.drop_count      = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_address_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_address_request_arbiter
// Description : Directed self-checking bench for address_request_arbiter
//               (NREQ=4, ADDRBITS=8, IDBITS=3). Expectations for the
//               duplicate test follow ARB_DUP_FILTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_address_request_arbiter;

    localparam int NREQ     = 4;
    localparam int ADDRBITS = 8;
    localparam int IDBITS   = 3;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    address_request_arbiter_if #(
        .NREQ     (NREQ),
        .ADDRBITS (ADDRBITS),
        .IDBITS   (IDBITS)
    ) bus ();

    address_request_arbiter #(
        .NREQ     (NREQ),
        .ADDRBITS (ADDRBITS),
        .IDBITS   (IDBITS)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int idx, input logic [ADDRBITS-1:0] a);
        bus.req_address[idx*ADDRBITS +: ADDRBITS] = a;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.req_valid   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.req_address   = '0;
        bus.req_valid     = '0;
        bus.storage_ready = 1'b0;
        do_reset();

        // Reset state
        check_value("rst_accept",   32'(bus.req_accept),      32'hF);
        check_value("rst_addr",     32'(bus.mem_address),     32'h0);
        check_value("rst_new",      32'(bus.mem_new_address), 32'h0);
        check_value("rst_grant",    32'(bus.grant_id),        32'h0);
        check_value("rst_drop",     32'(bus.drop_count),      32'h0);

        // 1: single request, two-cycle latency
        bus.storage_ready = 1'b1;
        set_addr(2, 8'h84);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        check_value("t1_accept_held", 32'(bus.req_accept),      32'hB);
        check_value("t1_new_early",   32'(bus.mem_new_address), 32'h0);
        tick();
        check_value("t1_new",         32'(bus.mem_new_address), 32'h1);
        check_value("t1_addr",        32'(bus.mem_address),     32'h84);
        check_value("t1_grant",       32'(bus.grant_id),        32'h2);
        check_value("t1_accept_free", 32'(bus.req_accept),      32'hF);
        tick();
        check_value("t1_new_low",     32'(bus.mem_new_address), 32'h0);
        check_value("t1_addr_hold",   32'(bus.mem_address),     32'h84);

        // 2: all four at once -> 0,1,2,3 back to back; then 3 and 0 -> 0 first
        do_reset();
        bus.storage_ready = 1'b1;
        set_addr(0, 8'h10);
        set_addr(1, 8'h20);
        set_addr(2, 8'h30);
        set_addr(3, 8'h40);
        bus.req_valid = 4'b1111;
        tick();
        bus.req_valid = '0;
        check_value("t2_all_held", 32'(bus.req_accept), 32'h0);
        for (int n = 0; n < NREQ; n++) begin
            tick();
            check_value("t2_new",   32'(bus.mem_new_address), 32'h1);
            check_value("t2_grant", 32'(bus.grant_id),        32'(n));
            check_value("t2_addr",  32'(bus.mem_address),     32'h10 * 32'(n + 1));
        end
        set_addr(0, 8'h66);
        set_addr(3, 8'h77);
        bus.req_valid = 4'b1001;
        tick();
        bus.req_valid = '0;
        check_value("t2b_gap",    32'(bus.mem_new_address), 32'h0);
        tick();
        check_value("t2b_grant0", 32'(bus.grant_id),        32'h0);
        check_value("t2b_addr0",  32'(bus.mem_address),     32'h66);
        tick();
        check_value("t2b_new3",   32'(bus.mem_new_address), 32'h1);
        check_value("t2b_grant3", 32'(bus.grant_id),        32'h3);
        check_value("t2b_addr3",  32'(bus.mem_address),     32'h77);

        // 3: full slot refuses a second strobe, counted as a drop
        bus.storage_ready = 1'b0;
        set_addr(1, 8'h55);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        check_value("t3_accept",   32'(bus.req_accept),      32'hD);
        set_addr(1, 8'h99);
        bus.req_valid = 4'b0010;
        check_value("t3_accept_v", 32'(bus.req_accept),      32'hD);
        tick();
        bus.req_valid = '0;
        check_value("t3_drop",     32'(bus.drop_count),      32'h1);
        check_value("t3_idle_new", 32'(bus.mem_new_address), 32'h0);
        check_value("t3_hold_addr",32'(bus.mem_address),     32'h77);
        check_value("t3_hold_id",  32'(bus.grant_id),        32'h3);
        bus.storage_ready = 1'b1;
        tick();
        check_value("t3_new",      32'(bus.mem_new_address), 32'h1);
        check_value("t3_addr",     32'(bus.mem_address),     32'h55);
        check_value("t3_grant",    32'(bus.grant_id),        32'h1);
        tick();
        check_value("t3_once",     32'(bus.mem_new_address), 32'h0);

        // 4: reset discards held slots
        bus.storage_ready = 1'b0;
        set_addr(0, 8'h01);
        set_addr(1, 8'h02);
        set_addr(2, 8'h03);
        bus.req_valid = 4'b0111;
        tick();
        bus.req_valid = '0;
        check_value("t4_held", 32'(bus.req_accept), 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.storage_ready = 1'b1;
        check_value("t4_accept", 32'(bus.req_accept),  32'hF);
        check_value("t4_drop",   32'(bus.drop_count),  32'h0);
        check_value("t4_addr",   32'(bus.mem_address), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_value("t4_no_new", 32'(bus.mem_new_address), 32'h0);
        end

        // 5: 300 refused strobes saturate the counter
        bus.storage_ready = 1'b0;
        set_addr(0, 8'h0A);
        bus.req_valid = 4'b0001;
        tick();
        check_value("t5_first_kept", 32'(bus.drop_count), 32'h0);
        for (int n = 0; n < 100; n++) tick();
        check_value("t5_drop100", 32'(bus.drop_count), 32'd100);
        for (int n = 0; n < 154; n++) tick();
        check_value("t5_drop254", 32'(bus.drop_count), 32'd254);
        tick();
        check_value("t5_drop255", 32'(bus.drop_count), 32'd255);
        for (int n = 0; n < 45; n++) tick();
        check_value("t5_saturate", 32'(bus.drop_count), 32'd255);
        bus.req_valid = '0;

        // 6: same address issued twice in a row
        do_reset();
        bus.storage_ready = 1'b1;
        set_addr(2, 8'h84);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        tick();
        check_value("t6_first_new",  32'(bus.mem_new_address), 32'h1);
        check_value("t6_first_addr", 32'(bus.mem_address),     32'h84);
        tick();
        set_addr(1, 8'h84);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        tick();
`ifdef ARB_DUP_FILTER_EN
        check_value("t6_dup_new",   32'(bus.mem_new_address), 32'h0);
        check_value("t6_dup_drop",  32'(bus.drop_count),      32'h1);
        check_value("t6_dup_grant", 32'(bus.grant_id),        32'h2);
        check_value("t6_dup_slot",  32'(bus.req_accept),      32'hF);
`else
        check_value("t6_dup_new",   32'(bus.mem_new_address), 32'h1);
        check_value("t6_dup_addr",  32'(bus.mem_address),     32'h84);
        check_value("t6_dup_grant", 32'(bus.grant_id),        32'h1);
        check_value("t6_dup_drop",  32'(bus.drop_count),      32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
